// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Brief    : Instruction fetch with req/ack imem handshake, stall/flush and a
//            one-entry hold buffer feeding the IF/ID register.
// Revision : 1.0
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        hd_i,
    input  logic        flush_i,
    output logic        pc_hold_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_inst_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        c_idle = 2'd0,
        c_wait = 2'd1,
        c_buf  = 2'd2
    } state_t;

    localparam int unsigned          c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_max  = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    state_t              r_state;
    logic                r_req;
    logic [31:0]         r_addr;
    logic                r_squash;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_err;
    logic [31:0]         r_buf_pc;
    logic [31:0]         r_buf_inst;
    logic                r_ifid_valid;
    logic [31:0]         r_ifid_pc;
    logic [31:0]         r_ifid_pc4;
    logic [31:0]         r_ifid_inst;

    logic w_wait_ack;
    logic w_issue;
    logic w_deliver_ack;

    assign w_wait_ack    = (r_state == c_wait) & imem_ack_i;
    // A squashed return never counts as accepted, so it cannot chain an issue.
    assign w_issue       = start_i & ~hd_i & ~flush_i &
                           ((r_state == c_idle) | (w_wait_ack & ~r_squash));
    assign w_deliver_ack = w_wait_ack & ~r_squash & ~flush_i & ~hd_i;

    assign pc_hold_o    = ~(w_issue | flush_i);
    assign imem_req_o   = r_req;
    assign imem_addr_o  = r_addr;
    assign ifid_valid_o = r_ifid_valid;
    assign ifid_pc_o    = r_ifid_pc;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_inst_o  = r_ifid_inst;
    assign err_o        = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_idle;
            r_req        <= 1'b0;
            r_addr       <= 32'd0;
            r_squash     <= 1'b0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_buf_pc     <= 32'd0;
            r_buf_inst   <= NOP_INST;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd4;
            r_ifid_inst  <= NOP_INST;
        end else begin
            if (flush_i) begin
                r_ifid_valid <= 1'b0;
                r_ifid_inst  <= NOP_INST;
            end else if (!hd_i) begin
                if (w_deliver_ack) begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_pc    <= r_addr;
                    r_ifid_pc4   <= r_addr + 32'd4;
                    r_ifid_inst  <= imem_data_i;
                end else if (r_state == c_buf) begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_pc    <= r_buf_pc;
                    r_ifid_pc4   <= r_buf_pc + 32'd4;
                    r_ifid_inst  <= r_buf_inst;
                end else begin
                    r_ifid_valid <= 1'b0;
                    r_ifid_inst  <= NOP_INST;
                end
            end

            case (r_state)
                c_idle: begin
                    if (w_issue) begin
                        r_state <= c_wait;
                        r_req   <= 1'b1;
                        r_addr  <= pc_i;
                        r_cnt   <= '0;
                    end
                end
                c_wait: begin
                    if (imem_ack_i) begin
                        r_squash <= 1'b0;
                        if (r_squash | flush_i) begin
                            r_req   <= 1'b0;
                            r_state <= c_idle;
                        end else if (hd_i) begin
                            r_buf_pc   <= r_addr;
                            r_buf_inst <= imem_data_i;
                            r_req      <= 1'b0;
                            r_state    <= c_buf;
                        end else if (w_issue) begin
                            r_addr <= pc_i;
                            r_cnt  <= '0;
                        end else begin
                            r_req   <= 1'b0;
                            r_state <= c_idle;
                        end
                    end else begin
                        if (flush_i) begin
                            r_squash <= 1'b1;
                        end
                        // Counter saturates; the stage keeps waiting after a timeout.
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (r_cnt >= c_cnt_last) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_buf: begin
                    if (flush_i | ~hd_i) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage sitting directly downstream of the PC register. It takes the current PC, fetches the instruction from instruction memory over a req/ack handshake and writes the IF/ID pipeline register.
- It tells the PC register when to advance. It honours the hazard-detection stall (hd_i) and the branch/jump flush (flush_i).
- It has a one-entry hold buffer, so an instruction that returns during a stall is kept rather than lost.

Parameters:
- NOP_INST, 32'h0000_0000, instruction word loaded into IF/ID for a bubble.
- TIMEOUT, 16, number of WAIT cycles without ack after which err_o is set.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  fetch enable (level); when low, no new requests are issued.
- pc_i  in  32  current PC from the PC register.
- hd_i  in  1  hazard stall; IF/ID holds and no new issue.
- flush_i  in  1  branch/jump taken; squash wrong-path fetches.
- pc_hold_o  out  1  PC register must not advance when high.
- imem_req_o  out  1  instruction-memory request.
- imem_addr_o  out  32  request address, registered.
- imem_ack_i  in  1  memory returns data this cycle.
- imem_data_i  in  32  instruction word, valid when ack is high.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_pc_o  out  32  address of the IF/ID instruction.
- ifid_pc4_o  out  32  ifid_pc_o + 4, modulo 2^32.
- ifid_inst_o  out  32  IF/ID instruction.
- err_o  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (rst_i high at an edge):
  - State goes to IDLE.
  - imem_req_o=0, imem_addr_o=0, ifid_valid_o=0, ifid_pc_o=0, ifid_pc4_o=4, ifid_inst_o=NOP_INST.
  - Squash flag cleared, buffer empty, timeout counter 0, err_o=0.
  - Any outstanding request is abandoned.
- Issue condition: issue = start_i & !hd_i & !flush_i & (state==IDLE | (state==WAIT & ack accepted this cycle)).
  - On issue: imem_addr_o<=pc_i, imem_req_o<=1, counter<=0, next state WAIT.
- pc_hold_o = !(issue | flush_i). This is combinational, and the PC advances in the same edge as an issue. On a flush the PC loads its redirect target.
- States:
  - IDLE:
    - req=0.
    - Issue if the issue condition holds.
    - Ack ignored.
  - WAIT:
    - req=1 and imem_addr_o held stable until ack.
    - Counter increments each cycle without ack; when it reaches TIMEOUT, err_o<=1. err_o stays set until reset. The stage keeps waiting.
    - Ack with squash flag set or flush_i high: data discarded, squash cleared, req<=0, next state IDLE.
    - Ack with hd_i low: IF/ID<={1, imem_addr_o, imem_addr_o+4, imem_data_i}. Back-to-back issue is allowed in the same cycle, staying in WAIT; otherwise req<=0 and next state IDLE.
    - Ack with hd_i high: data goes to the buffer, req<=0, next state BUF.
  - BUF:
    - req=0, ack ignored.
    - flush_i: buffer dropped, next state IDLE.
    - Else if !hd_i: buffer moves to IF/ID, next state IDLE. The next issue can occur no earlier than the following cycle.
- Squash flag: set when flush_i is high in WAIT without ack.
- IF/ID priority, highest first:
  1. rst_i.
  2. flush_i: bubble, meaning valid=0, inst=NOP_INST, pc/pc4 unchanged.
  3. hd_i: hold all fields.
  4. Delivery from ack or from the buffer.
  5. Otherwise bubble.
- Simultaneous events:
  - flush_i together with an ack: flush wins, no IF/ID write, no issue.
  - flush_i together with hd_i: flush wins.
  - start_i falling mid-WAIT: the outstanding fetch completes normally; no new issue.
- imem_addr_o+4 wraps at 32'hFFFF_FFFC -> 0.
- Throughput: one instruction per cycle when ack arrives in the first WAIT cycle. With latency N, the bench sees one valid IF/ID entry every N cycles, with bubbles in between.

Test Plan:
- Reset, start_i=1, pc_i steps 0,4,8, ack in the first WAIT cycle -> IF/ID shows pc 0,4,8 on consecutive cycles, inst=imem_data_i, pc4=4,8,12, pc_hold_o=0 on each issue cycle.
- Ack latency 3, pc_i=0x100 -> imem_addr_o stays 0x100 for 3 cycles, ifid_valid_o pattern is 0,0,1 repeating, pc_hold_o=1 while waiting.
- hd_i=1 in the ack cycle for inst 0x8C010004 at pc 0x20 -> IF/ID keeps its old value, state BUF, req=0. After hd_i drops: IF/ID={1,0x20,0x24,0x8C010004}.
- flush_i pulse in WAIT at addr 0x30, target pc_i=0x40, ack 2 cycles later -> data discarded, IF/ID valid=0 inst=NOP_INST, next request addr=0x40.
- TIMEOUT=4, no ack for 4 cycles -> err_o=1 on the 4th cycle edge; stays 1 after a later ack and a normal delivery.
- rst_i mid-WAIT, then a stray ack the next cycle -> req=0, IF/ID stays in the reset bubble, err_o=0, no IF/ID write.
